// File: rtl/viterbi_batch_ctrl_if.sv
// BRAM port B and Viterbi decoder signal bundle shared by the batch controller
// (master) and the memory/decoder side (slave).
interface viterbi_batch_ctrl_if #(
  parameter int LENIN  = 10,
  parameter int LENOUT = 5,
  parameter int SOW    = 16
);
  logic [15:0]       mem_addr;
  logic [7:0]        mem_din;
  logic              mem_wen;
  logic [7:0]        mem_dout;
  logic              dec_rst;
  logic [LENIN-1:0]  dec_codein;
  logic [SOW-1:0]    dec_state_out;
  logic [LENOUT-1:0] dec_codeout;
  logic              dec_finish;

  modport master (
    output mem_addr, mem_din, mem_wen, dec_rst, dec_codein, dec_state_out,
    input  mem_dout, dec_codeout, dec_finish
  );

  modport slave (
    input  mem_addr, mem_din, mem_wen, dec_rst, dec_codein, dec_state_out,
    output mem_dout, dec_codeout, dec_finish
  );
endinterface

// File: rtl/viterbi_batch_ctrl.sv
// Batch sequencer: reads a job table from BRAM, runs the Viterbi decoder once per
// job, writes results, a saturating total cycle count and a status byte.
module viterbi_batch_ctrl #(
  parameter int LENIN    = 10,
  parameter int LENOUT   = 5,
  parameter int SOW      = 16,
  parameter int MAX_JOBS = 32,
  parameter int TIMEOUT  = 1024
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                memctl,
  viterbi_batch_ctrl_if.master bus,
  output logic                trigger,
  output logic                busy
);
  localparam int              CW          = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]   TIMEOUT_CNT = CW'(TIMEOUT);
  localparam logic [7:0]      MAX_N       = 8'(MAX_JOBS);
  localparam logic [15:0]     JOB_BASE    = 16'd16;
  localparam logic [15:0]     RES_BASE    = 16'd160;
  localparam logic [15:0]     CYC_BASE    = 16'd200;
  localparam logic [15:0]     STAT_ADDR   = 16'd204;

  typedef enum logic [2:0] {
    IDLE, RD_HDR, RD_JOB, RUN, WR_RES, WR_CYC, WR_STAT, DONE
  } state_t;

  state_t         state;
  logic [2:0]     phase;
  logic [7:0]     n_jobs;
  logic [7:0]     job;
  logic [CW-1:0]  job_cnt;
  logic [31:0]    total;
  logic [7:0]     b0, b1, b2;
  logic           flag_tmo, flag_bad;

  logic [7:0]     result_byte;
  logic [32:0]    sum_wide;
  logic [31:0]    total_sum;
  logic [31:0]    total_shr;
  logic [15:0]    code_word;
  logic [15:0]    state_word;
  logic [7:0]     next_job;
  logic [15:0]    next_base;
  logic [CW-1:0]  cnt_inc;
  logic [7:0]     status;
  logic           more_jobs;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    result_byte                = '0;
    result_byte[LENOUT-1:0]    = bus.dec_codeout;
    sum_wide                   = {1'b0, total} + 33'(job_cnt);
    total_sum                  = sum_wide[32] ? 32'hFFFF_FFFF : sum_wide[31:0];
    total_shr                  = total >> {phase + 3'd1, 3'b000};
    code_word                  = {b1, b0};
    state_word                 = {bus.mem_dout, b2};
    next_job                   = job + 8'd1;
    next_base                  = JOB_BASE + {6'd0, next_job, 2'b00};
    cnt_inc                    = job_cnt + 1'b1;
    status                     = {5'd0, flag_bad, flag_tmo, 1'b1};
    more_jobs                  = next_job < n_jobs;
  end

  // NOTE: all state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state             <= IDLE;
      phase             <= '0;
      n_jobs            <= '0;
      job               <= '0;
      job_cnt           <= '0;
      total             <= '0;
      b0                <= '0;
      b1                <= '0;
      b2                <= '0;
      flag_tmo          <= 1'b0;
      flag_bad          <= 1'b0;
      bus.mem_addr      <= '0;
      bus.mem_din       <= '0;
      bus.mem_wen       <= 1'b0;
      bus.dec_rst       <= 1'b0;
      bus.dec_codein    <= '0;
      bus.dec_state_out <= '0;
      trigger           <= 1'b0;
      busy              <= 1'b0;
    end else if (memctl) begin
      // ARM reclaims the memory: abort from any state and forget the batch.
      state        <= IDLE;
      phase        <= '0;
      job          <= '0;
      total        <= '0;
      flag_tmo     <= 1'b0;
      flag_bad     <= 1'b0;
      bus.mem_addr <= '0;
      bus.mem_din  <= '0;
      bus.mem_wen  <= 1'b0;
      bus.dec_rst  <= 1'b0;
      trigger      <= 1'b0;
      busy         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state        <= RD_HDR;
          phase        <= '0;
          bus.mem_addr <= '0;
          busy         <= 1'b1;
        end
        RD_HDR: begin
          if (phase == 3'd0) begin
            phase <= 3'd1;
          end else begin
            n_jobs <= bus.mem_dout;
            phase  <= '0;
            if (bus.mem_dout == 8'd0 || bus.mem_dout > MAX_N) begin
              flag_bad     <= bus.mem_dout > MAX_N;
              state        <= WR_CYC;
              bus.mem_addr <= CYC_BASE;
              bus.mem_din  <= total[7:0];
              bus.mem_wen  <= 1'b1;
            end else begin
              job          <= '0;
              state        <= RD_JOB;
              bus.mem_addr <= JOB_BASE;
            end
          end
        end
        RD_JOB: begin
          // Address leads data by one cycle: byte k lands on the edge ending phase k+1.
          phase <= phase + 3'd1;
          if (phase < 3'd3) bus.mem_addr <= bus.mem_addr + 16'd1;
          case (phase)
            3'd1: b0 <= bus.mem_dout;
            3'd2: b1 <= bus.mem_dout;
            3'd3: b2 <= bus.mem_dout;
            3'd4: begin
              bus.dec_codein    <= code_word[LENIN-1:0];
              bus.dec_state_out <= state_word[SOW-1:0];
              bus.dec_rst       <= 1'b1;
              job_cnt           <= '0;
              phase             <= '0;
              state             <= RUN;
            end
            default: ;
          endcase
        end
        RUN: begin
          job_cnt <= cnt_inc;
          if (bus.dec_finish || cnt_inc == TIMEOUT_CNT) begin
            if (!bus.dec_finish) flag_tmo <= 1'b1;
            bus.mem_din  <= bus.dec_finish ? result_byte : 8'hFF;
            bus.mem_addr <= RES_BASE + {8'd0, job};
            bus.mem_wen  <= 1'b1;
            bus.dec_rst  <= 1'b0;
            state        <= WR_RES;
          end
        end
        WR_RES: begin
          total <= total_sum;
          phase <= '0;
          if (more_jobs) begin
            job          <= next_job;
            bus.mem_addr <= next_base;
            bus.mem_wen  <= 1'b0;
            state        <= RD_JOB;
          end else begin
            bus.mem_addr <= CYC_BASE;
            bus.mem_din  <= total_sum[7:0];
            state        <= WR_CYC;
          end
        end
        WR_CYC: begin
          if (phase == 3'd3) begin
            bus.mem_addr <= STAT_ADDR;
            bus.mem_din  <= status;
            state        <= WR_STAT;
          end else begin
            phase        <= phase + 3'd1;
            bus.mem_addr <= bus.mem_addr + 16'd1;
            bus.mem_din  <= total_shr[7:0];
          end
        end
        WR_STAT: begin
          bus.mem_wen <= 1'b0;
          trigger     <= 1'b1;
          busy        <= 1'b0;
          state       <= DONE;
        end
        DONE: ;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_viterbi_batch_ctrl.sv
// Self-checking bench: BRAM and decoder models, a job-level reference model and
// a per-cycle compare process, driven by directed batches.
module tb_viterbi_batch_ctrl;
  localparam int TIMEOUT  = 1024;
  localparam int MAX_JOBS = 32;

  logic clk = 1'b0;
  logic rstn, memctl;
  logic trigger, busy;

  viterbi_batch_ctrl_if #(.LENIN(10), .LENOUT(5), .SOW(16)) bus ();

  viterbi_batch_ctrl #(
    .LENIN(10), .LENOUT(5), .SOW(16), .MAX_JOBS(MAX_JOBS), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk     (clk),
    .rstn    (rstn),
    .memctl  (memctl),
    .bus     (bus),
    .trigger (trigger),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- BRAM port B model (1-cycle read latency) ----------------
  logic [7:0] bram [256];
  logic [7:0] img  [256];
  logic       load;

  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 256; i++) bram[i] <= img[i];
    end else if (bus.mem_wen) begin
      bram[bus.mem_addr[7:0]] <= bus.mem_din;
    end
    bus.mem_dout <= bram[bus.mem_addr[7:0]];
  end

  // ---------------- decoder model: job identified by its code word ----------------
  logic [15:0] job_raw   [8];
  logic [15:0] job_state [8];
  int          job_lat   [8];   // 0 = never finishes
  logic [4:0]  job_out   [8];
  logic [9:0]  job_code  [8];
  int          n_tbl;
  logic        stale_fin;
  int          dcnt;

  always @(posedge clk or negedge rstn) begin
    if (!rstn)            dcnt <= 0;
    else if (bus.dec_rst) dcnt <= dcnt + 1;
    else                  dcnt <= 0;
  end

  always_comb begin
    bus.dec_finish  = stale_fin;
    bus.dec_codeout = '0;
    if (bus.dec_rst) begin
      bus.dec_finish = 1'b0;
      for (int i = 0; i < 8; i++) begin
        if (i < n_tbl && job_code[i] == bus.dec_codein) begin
          bus.dec_finish  = (job_lat[i] != 0) && (dcnt >= job_lat[i] - 1);
          bus.dec_codeout = job_out[i];
        end
      end
    end
  end

  // ---------------- job-level reference model ----------------
  logic [23:0] wq [$];     // expected writes {addr, data} in order
  int          lat_total;  // cycles from RD_HDR entry up to DONE entry
  int          exp_high;
  logic        exp_bad;

  task automatic build(input int n);
    longint     tot;
    logic       tmo;
    int         run;
    logic [7:0] res;
    for (int i = 0; i < 256; i++) img[i] = 8'h00;
    img[0]    = 8'(n);
    wq.delete();
    tot       = 0;
    tmo       = 1'b0;
    exp_high  = 0;
    n_tbl     = n;
    exp_bad   = (n > MAX_JOBS);
    lat_total = 7;
    if (!exp_bad) begin
      for (int j = 0; j < n; j++) begin
        img[16 + 4*j]     = job_raw[j][7:0];
        img[16 + 4*j + 1] = job_raw[j][15:8];
        img[16 + 4*j + 2] = job_state[j][7:0];
        img[16 + 4*j + 3] = job_state[j][15:8];
        job_code[j]       = job_raw[j][9:0];
        if (job_lat[j] == 0 || job_lat[j] > TIMEOUT) begin
          run = TIMEOUT; res = 8'hFF; tmo = 1'b1;
        end else begin
          run = job_lat[j]; res = {3'b000, job_out[j]};
        end
        tot       += run;
        exp_high  += run;
        lat_total += 6 + run;
        wq.push_back({16'(160 + j), res});
      end
    end
    if (tot > 64'hFFFF_FFFF) tot = 64'hFFFF_FFFF;
    for (int b = 0; b < 4; b++) wq.push_back({16'(200 + b), 8'(tot >> (8*b))});
    wq.push_back({16'd204, {5'd0, exp_bad, tmo, 1'b1}});
  endtask

  // ---------------- per-cycle compare process ----------------
  logic chk_en;
  int   m, cur_job, low_run, high_cnt, trig_rise;
  logic prev_rst, trig_seen;

  always @(negedge clk) begin
    if (!chk_en) begin
      m = 0;
    end else begin
      if (m == 0) begin
        cur_job = 0; low_run = 0; high_cnt = 0; prev_rst = 1'b0;
        trig_seen = 1'b0; trig_rise = -1;
      end
      check("busy", busy, (m >= 1 && m <= lat_total));
      check("trigger", trigger, (m >= lat_total + 1));
      if (trigger && !trig_seen) begin trig_seen = 1'b1; trig_rise = m; end
      if (bus.mem_wen) begin
        if (wq.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_write: addr %0d data 0x%02h, required no write", bus.mem_addr, bus.mem_din);
        end else begin
          check("write", {bus.mem_addr, bus.mem_din}, wq.pop_front());
        end
      end
      if (bus.dec_rst) begin
        check("codein", bus.dec_codein, job_code[cur_job[2:0]]);
        check("state_out", bus.dec_state_out, job_state[cur_job[2:0]]);
        if (!prev_rst && cur_job > 0) check("dec_rst_gap", low_run, 6);
        high_cnt++;
      end else begin
        if (prev_rst) begin cur_job++; low_run = 0; end
        low_run++;
      end
      if (exp_bad && m >= 1 && m <= lat_total && !bus.mem_wen) check("hdr_only_read", bus.mem_addr, 0);
      prev_rst = bus.dec_rst;
      m++;
    end
  end

  task automatic load_image();
    @(posedge clk); #1 load = 1'b1;
    @(posedge clk); #1 load = 1'b0;
  endtask

  task automatic run_batch();
    load_image();
    @(posedge clk); #1 memctl = 1'b0; chk_en = 1'b1;
    repeat (lat_total + 4) @(negedge clk);
    #1 chk_en = 1'b0;
    check("writes_left", wq.size(), 0);
    check("dec_high_cycles", high_cnt, exp_high);
    @(posedge clk); #1 memctl = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic set_job(input int j, input logic [15:0] raw, input logic [15:0] st,
                         input int lat, input logic [4:0] out);
    job_raw[j] = raw; job_state[j] = st; job_lat[j] = lat; job_out[j] = out;
  endtask

  initial begin
    rstn = 1'b1; memctl = 1'b1; load = 1'b0; chk_en = 1'b0;
    stale_fin = 1'b0; n_tbl = 0;
    for (int i = 0; i < 8; i++) set_job(i, 16'h0, 16'h0, 1, 5'h0);
    #1 rstn = 1'b0;
    #12;
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_mem_wen", bus.mem_wen, 0);
    check("rst_dec_rst", bus.dec_rst, 0);
    check("rst_trigger", trigger, 0);
    check("rst_busy", busy, 0);
    @(negedge clk) rstn = 1'b1;

    // N=1: 7-cycle job, stale finish held high outside RUN
    stale_fin = 1'b1;
    set_job(0, 16'h02A5, 16'hB4E1, 7, 5'h13);
    build(1); run_batch();
    check("t1_result", bram[160], 8'h13);
    check("t1_total", {bram[203], bram[202], bram[201], bram[200]}, 32'd7);
    check("t1_status", bram[204], 8'h01);
    check("t1_trig_rise", trig_rise, 21);

    // N=3, latencies 5/9/12; second code word carries junk above bit 9
    set_job(0, 16'h0111, 16'h1234, 5, 5'h01);
    set_job(1, 16'hFD17, 16'hABCD, 9, 5'h1F);
    set_job(2, 16'h0333, 16'h00FF, 12, 5'h0A);
    build(3); run_batch();
    check("t2_res1", bram[161], 8'h1F);
    check("t2_total", {bram[203], bram[202], bram[201], bram[200]}, 32'd26);
    check("t2_trig_rise", trig_rise, 52);
    stale_fin = 1'b0;

    // N=0
    build(0); run_batch();
    check("t3_total", {bram[203], bram[202], bram[201], bram[200]}, 32'd0);
    check("t3_status", bram[204], 8'h01);
    check("t3_trig_rise", trig_rise, 8);

    // N=40 > MAX_JOBS
    build(40); run_batch();
    check("t4_status", bram[204], 8'h05);

    // N=2, second job never finishes
    set_job(0, 16'h0042, 16'h5555, 3, 5'h07);
    set_job(1, 16'h0043, 16'hAAAA, 0, 5'h09);
    build(2); run_batch();
    check("t5_res0", bram[160], 8'h07);
    check("t5_res1", bram[161], 8'hFF);
    check("t5_status", bram[204], 8'h03);
    check("t5_total", {bram[203], bram[202], bram[201], bram[200]}, 32'd1027);

    // abort mid-RUN, then clean restart
    set_job(0, 16'h0101, 16'h1111, 20, 5'h11);
    set_job(1, 16'h0202, 16'h2222, 20, 5'h12);
    build(2); load_image();
    @(posedge clk); #1 memctl = 1'b0;
    for (int i = 0; i < 40 && !bus.dec_rst; i++) @(negedge clk);
    check("abort_run_reached", bus.dec_rst, 1);
    repeat (3) @(negedge clk);
    @(posedge clk); #1 memctl = 1'b1;
    @(posedge clk); #1;
    check("abort_run_dec_rst", bus.dec_rst, 0);
    check("abort_run_wen", bus.mem_wen, 0);
    check("abort_run_busy", busy, 0);
    repeat (2) @(posedge clk);
    run_batch();
    check("t6_res1", bram[161], 8'h12);
    check("t6_total", {bram[203], bram[202], bram[201], bram[200]}, 32'd40);

    // abort mid-WR_CYC, then clean restart
    set_job(0, 16'h0155, 16'h7777, 4, 5'h15);
    build(1); load_image();
    @(posedge clk); #1 memctl = 1'b0;
    for (int i = 0; i < 60 && !(bus.mem_wen && bus.mem_addr == 16'd201); i++) @(negedge clk);
    check("abort_cyc_reached", {bus.mem_wen, bus.mem_addr}, {1'b1, 16'd201});
    @(posedge clk); #1 memctl = 1'b1;
    @(posedge clk); #1;
    check("abort_cyc_wen", bus.mem_wen, 0);
    check("abort_cyc_dec_rst", bus.dec_rst, 0);
    check("abort_cyc_busy", busy, 0);
    check("abort_cyc_trigger", trigger, 0);
    repeat (2) @(posedge clk);
    run_batch();
    check("t7_total", {bram[203], bram[202], bram[201], bram[200]}, 32'd4);
    check("t7_status", bram[204], 8'h01);

    // asynchronous reset pulse mid-RUN
    set_job(0, 16'h03C3, 16'h9E37, 20, 5'h03);
    build(1); load_image();
    @(posedge clk); #1 memctl = 1'b0;
    repeat (12) @(negedge clk);
    check("rstn_pre_running", bus.dec_rst, 1);
    #2 rstn = 1'b0;
    #1;
    check("rstn_mem_addr", bus.mem_addr, 0);
    check("rstn_mem_din", bus.mem_din, 0);
    check("rstn_mem_wen", bus.mem_wen, 0);
    check("rstn_dec_rst", bus.dec_rst, 0);
    check("rstn_codein", bus.dec_codein, 0);
    check("rstn_state_out", bus.dec_state_out, 0);
    check("rstn_trigger", trigger, 0);
    check("rstn_busy", busy, 0);
    memctl = 1'b1;
    #2 rstn = 1'b1;
    repeat (3) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
